// File: rtl/proc_control.sv
// -----------------------------------------------------------------------------
// proc_control
//   Control FSM for the 16-bit bus processor, sitting directly upstream of the
//   bus mux. It latches a 9-bit instruction from DIN in T0 and sequences the
//   timesteps T0..T3. Every control output is decoded combinationally from
//   {step, IR}.
//
//   Instruction format: IR[8:6] = opcode, IR[5:3] = X, IR[2:0] = Y
//     000 mv  Rx,Ry   001 mvi Rx,#D   010 add Rx,Ry   011 sub Rx,Ry
//
//   Build option: define PROC_ILLEGAL_TRAP_EN to trap opcodes 1xx. A trapped
//   opcode sets the sticky Illegal flag and parks the FSM in T1 until reset.
//   When the macro is not defined, opcodes 1xx retire as NOPs and Illegal is
//   tied to 0.
//
// Ports
//   Clock    in   1       system clock, rising edge
//   Resetn   in   1       asynchronous, active-low reset
//   Run      in   1       start fetch; sampled only in T0
//   DIN      in   DATA_W  instruction / immediate input
//   BusSel   out  10      one-hot mux select: [0]=DIN, [1]=G, [9-k]=Rk
//   RegIn    out  8       load enable for R0..R7 (bit k = Rk)
//   AIn      out  1       load A from bus
//   GIn      out  1       load G from ALU
//   AddSub   out  1       ALU op: 0 = A+bus, 1 = A-bus
//   Done     out  1       instruction retires this cycle
//   IR       out  9       current instruction register (debug)
//   Illegal  out  1       sticky undefined-opcode flag
// -----------------------------------------------------------------------------
module proc_control #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [9:0]        BusSel,
  output logic [7:0]        RegIn,
  output logic              AIn,
  output logic              GIn,
  output logic              AddSub,
  output logic              Done,
  output logic [8:0]        IR,
  output logic              Illegal
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [9:0] SEL_DIN = 10'b00_0000_0001;
  localparam logic [9:0] SEL_G   = 10'b00_0000_0010;

  // The mux orders the registers in reverse: Rk sits at bit 9-k.
  function automatic logic [9:0] reg_sel(input logic [2:0] k);
    return 10'b1 << (4'd9 - {1'b0, k});
  endfunction

  function automatic logic [7:0] reg_en(input logic [2:0] k);
    return 8'b1 << k;
  endfunction

  step_e      step_q, step_d;
  logic [8:0] ir_q, ir_d;
  logic [2:0] opcode, rx, ry;

  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

`ifdef PROC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

  generate
    if (DATA_W > 9) begin : g_din_hi
      // DIN carries immediates that are wider than IR. Those upper bits go to
      // the bus mux only.
      logic unused_din_hi;
      assign unused_din_hi = ^DIN[DATA_W-1:9];
    end
  endgenerate

  always_comb begin
    // NOTE: every output and next-state value gets a default first. A path
    // that leaves any of them unassigned would infer a latch.
    step_d = step_q;
    ir_d   = ir_q;
    BusSel = '0;
    RegIn  = '0;
    AIn    = 1'b0;
    GIn    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
`ifdef PROC_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif

    unique case (step_q)
      T0: begin
        if (Run) begin
          ir_d   = DIN[8:0];
          step_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            BusSel = reg_sel(ry);
            RegIn  = reg_en(rx);
            Done   = 1'b1;
            step_d = T0;
          end
          OP_MVI: begin
            BusSel = SEL_DIN;
            RegIn  = reg_en(rx);
            Done   = 1'b1;
            step_d = T0;
          end
          OP_ADD, OP_SUB: begin
            BusSel = reg_sel(rx);
            AIn    = 1'b1;
            step_d = T2;
          end
          default: begin
`ifdef PROC_ILLEGAL_TRAP_EN
            // Park here with every enable low. Only reset leaves this state.
            illegal_d = 1'b1;
            step_d    = T1;
`else
            Done   = 1'b1;
            step_d = T0;
`endif
          end
        endcase
      end
      T2: begin
        BusSel = reg_sel(ry);
        GIn    = 1'b1;
        AddSub = (opcode == OP_SUB);
        step_d = T3;
      end
      T3: begin
        BusSel = SEL_G;
        RegIn  = reg_en(rx);
        Done   = 1'b1;
        step_d = T0;
      end
      default: step_d = T0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // updates from the same pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_q    <= T0;
      ir_q      <= '0;
`ifdef PROC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      step_q    <= step_d;
      ir_q      <= ir_d;
`ifdef PROC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign IR = ir_q;

endmodule

// File: tb/tb_proc_control.sv
// -----------------------------------------------------------------------------
// tb_proc_control
//   Scoreboard bench for proc_control. Stimulus pushes the expected control word
//   for each active cycle, together with the cycle number, into a queue. A
//   monitor pops and compares whenever the DUT drives any control output.
// -----------------------------------------------------------------------------
module tb_proc_control;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic [9:0]  BusSel;
  logic [7:0]  RegIn;
  logic        AIn, GIn, AddSub, Done, Illegal;
  logic [8:0]  IR;

  proc_control #(.DATA_W(16)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .BusSel (BusSel),
    .RegIn  (RegIn),
    .AIn    (AIn),
    .GIn    (GIn),
    .AddSub (AddSub),
    .Done   (Done),
    .IR     (IR),
    .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [9:0] bus;
    logic [7:0] reg_in;
    logic       a_in;
    logic       g_in;
    logic       add_sub;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [9:0] b, input logic [7:0] r,
                      input logic a, input logic g, input logic s, input logic d);
    exp_t e;
    e.cyc = c; e.bus = b; e.reg_in = r;
    e.a_in = a; e.g_in = g; e.add_sub = s; e.done = d;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge. The DUT samples them at
  // the following edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Monitor: sample mid-cycle and score every cycle that has control activity.
  always @(negedge Clock) begin
    exp_t e;
    if (Resetn === 1'b1 &&
        (BusSel != 10'b0 || RegIn != 8'b0 || AIn || GIn || AddSub || Done)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: cycle %0d got bus=%b regin=%b a=%b g=%b as=%b done=%b want idle",
                 cyc, BusSel, RegIn, AIn, GIn, AddSub, Done);
      end else begin
        e = sb.pop_front();
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("event_ctrl", {BusSel, RegIn, AIn, GIn, AddSub, Done},
              {e.bus, e.reg_in, e.a_in, e.g_in, e.add_sub, e.done});
      end
    end
  end

  int c;

  initial begin
    // Reset with Run high: everything quiet, IR cleared.
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 16'hFE0A;                       // mv R1,R2 in the low 9 bits
    repeat (2) step();
    check("rst_outputs", {BusSel, RegIn, AIn, GIn, AddSub, Done, Illegal}, '0);
    check("rst_ir", IR, 9'h000);

    // Release: the first edge latches DIN[8:0], and mv R1,R2 retires in T1.
    Resetn = 1'b1;
    push(cyc + 1, 10'b0010000000, 8'b00000010, 0, 0, 0, 1);
    step();
    Run = 1'b0;
    check("ir_after_release", IR, 9'h00A);
    step();

    // mvi R2,#0x00A5
    DIN = 16'h0050;
    Run = 1'b1;
    push(cyc + 1, 10'b0000000001, 8'b00000100, 0, 0, 0, 1);
    step();
    Run = 1'b0;
    DIN = 16'h00A5;
    check("ir_mvi", IR, 9'h050);
    step();

    // add R1,R6
    c   = cyc;
    DIN = 16'h008E;
    Run = 1'b1;
    push(c + 1, 10'b0100000000, 8'b00000000, 1, 0, 0, 0);
    push(c + 2, 10'b0000001000, 8'b00000000, 0, 1, 0, 0);
    push(c + 3, 10'b0000000010, 8'b00000010, 0, 0, 0, 1);
    step();
    Run = 1'b0;
    DIN = 16'hFFFF;                          // ignored outside T0
    repeat (3) step();

    // sub R0,R7: Done comes 3 edges after the Run sample.
    c   = cyc;
    DIN = 16'h00C7;
    Run = 1'b1;
    push(c + 1, 10'b1000000000, 8'b00000000, 1, 0, 0, 0);
    push(c + 2, 10'b0000000100, 8'b00000000, 0, 1, 1, 0);
    push(c + 3, 10'b0000000010, 8'b00000001, 0, 0, 0, 1);
    step();
    Run = 1'b0;
    check("ir_sub", IR, 9'h0C7);
    repeat (3) step();

    // mv R3,R3 reads and writes the same register.
    DIN = 16'h001B;
    Run = 1'b1;
    push(cyc + 1, 10'b0001000000, 8'b00001000, 0, 0, 0, 1);
    step();
    Run = 1'b0;
    step();

    // Run held high: mv R4,R5, then add R4,R4 fetched in the T0 after Done.
    // A Run pulse during T2 of the add must not start anything.
    c   = cyc;
    DIN = 16'h0025;
    Run = 1'b1;
    push(c + 1, 10'b0000010000, 8'b00010000, 0, 0, 0, 1);
    push(c + 3, 10'b0000100000, 8'b00000000, 1, 0, 0, 0);
    push(c + 4, 10'b0000100000, 8'b00000000, 0, 1, 0, 0);
    push(c + 5, 10'b0000000010, 8'b00010000, 0, 0, 0, 1);
    step();                                  // c+1: mv T1
    DIN = 16'h00A4;
    step();                                  // c+2: T0, add sampled at next edge
    step();                                  // c+3: add T1
    Run = 1'b0;
    check("ir_b2b", IR, 9'h0A4);
    step();                                  // c+4: T2
    Run = 1'b1;
    DIN = 16'h0050;
    step();                                  // c+5: T3
    Run = 1'b0;
    repeat (2) step();

    // Reset during T2 of add R2,R3: outputs drop at once, nothing retires.
    c   = cyc;
    DIN = 16'h0093;
    Run = 1'b1;
    push(c + 1, 10'b0010000000, 8'b00000000, 1, 0, 0, 0);
    step();
    Run = 1'b0;
    step();                                  // now in T2
    Resetn = 1'b0;
    #1;
    check("midrst_outputs", {BusSel, RegIn, AIn, GIn, AddSub, Done}, '0);
    check("midrst_ir", IR, 9'h000);
    step();
    Resetn = 1'b1;
    repeat (2) step();

    // Opcode 111
    DIN = 16'h01C0;
    Run = 1'b1;
`ifdef PROC_ILLEGAL_TRAP_EN
    step();
    DIN = 16'h0050;                          // Run stays high and must be ignored
    repeat (10) step();
    Run = 1'b0;
    check("trap_illegal", Illegal, 1'b1);
    check("trap_ir", IR, 9'h1C0);
    Resetn = 1'b0;
    #1;
    check("trap_rst_illegal", Illegal, 1'b0);
    check("trap_rst_ir", IR, 9'h000);
    step();
    Resetn = 1'b1;
    step();
`else
    push(cyc + 1, 10'b0000000000, 8'b00000000, 0, 0, 0, 1);
    step();
    Run = 1'b0;
    check("nop_illegal", Illegal, 1'b0);
    check("nop_ir", IR, 9'h1C0);
    step();
`endif

    repeat (3) step();
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
